// File: rtl/zz_sched.sv
// rtl/zz_sched.sv - zig-zag product scheduler: walks a job's tiles and issues weight/data addresses
// Offsets come from an external zig-zag AGU that this block steps and clears.
module zz_sched #(
  parameter int BWADDR = 21,
  parameter int BPREC  = 4,
  parameter int BTILE  = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [BPREC-1:0]  pw,
  input  logic [BPREC-1:0]  pd,
  input  logic [BWADDR-1:0] wbase,
  input  logic [BWADDR-1:0] dbase,
  input  logic [BTILE-1:0]  ntile,
  input  logic              stall,
  input  logic [BPREC-1:0]  zz_offw,
  input  logic [BPREC-1:0]  zz_offd,
  output logic              zz_step,
  output logic              zz_clr,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [BWADDR-1:0] waddr,
  output logic [BWADDR-1:0] daddr,
  output logic              acc_sh,
  output logic              tile_last
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [BPREC-1:0]    pw_q, pw_d, pd_q, pd_d;
  logic [BWADDR-1:0]   wbase_q, wbase_d, dbase_q, dbase_d;
  logic [BTILE-1:0]    ntile_q, ntile_d, t_q, t_d;
  logic [2*BPREC-1:0]  pc_q, pc_d;
  logic [BPREC:0]      diag_q, diag_d;
  logic                busy_q, busy_d, done_q, done_d;

  logic [BPREC:0]      diag_sum;
  logic [2*BPREC-1:0]  pc_last;
  logic                issue, last, final_tile;

  assign diag_sum   = {1'b0, zz_offw} + {1'b0, zz_offd};
  assign pc_last    = (2*BPREC)'(pw_q) * (2*BPREC)'(pd_q) - (2*BPREC)'(1);
  assign issue      = (state_q == RUN) && !stall;
  assign last       = issue && (pc_q == pc_last);
  assign final_tile = (t_q == ntile_q - BTILE'(1));

  // Address arithmetic wraps naturally at BWADDR bits.
  assign waddr = wbase_q + BWADDR'(t_q) * BWADDR'(pw_q) + BWADDR'(zz_offw);
  assign daddr = dbase_q + BWADDR'(t_q) * BWADDR'(pd_q) + BWADDR'(zz_offd);

  assign valid     = issue;
  assign zz_step   = issue;
  assign tile_last = last;
  assign zz_clr    = (state_q == INIT) || last;
  assign acc_sh    = issue && (pc_q != '0) && (diag_sum != diag_q);
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    pd_d    = pd_q;
    wbase_d = wbase_q;
    dbase_d = dbase_q;
    ntile_d = ntile_q;
    t_d     = t_q;
    pc_d    = pc_q;
    diag_d  = diag_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pw_d    = pw;
          pd_d    = pd;
          wbase_d = wbase;
          dbase_d = dbase;
          ntile_d = ntile;
          state_d = INIT;
        end
      end
      INIT: begin
        pc_d   = '0;
        t_d    = '0;
        diag_d = '0;
        if (pw_q == '0 || pd_q == '0 || ntile_q == '0) state_d = DONE;
        else                                           state_d = RUN;
      end
      RUN: begin
        if (issue) begin
          diag_d = diag_sum;
          if (last) begin
            pc_d = '0;
            t_d  = t_q + BTILE'(1);
            if (final_tile) state_d = DONE;
          end else begin
            pc_d = pc_q + (2*BPREC)'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      pw_q    <= '0;
      pd_q    <= '0;
      wbase_q <= '0;
      dbase_q <= '0;
      ntile_q <= '0;
      t_q     <= '0;
      pc_q    <= '0;
      diag_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      pd_q    <= pd_d;
      wbase_q <= wbase_d;
      dbase_q <= dbase_d;
      ntile_q <= ntile_d;
      t_q     <= t_d;
      pc_q    <= pc_d;
      diag_q  <= diag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_zz_sched.sv
// tb/tb_zz_sched.sv - scoreboard bench for zz_sched with a behavioural zig-zag AGU
module tb_zz_sched;

  localparam int BWADDR = 21;
  localparam int BPREC  = 4;
  localparam int BTILE  = 8;

  typedef struct {
    logic [BWADDR-1:0] w;
    logic [BWADDR-1:0] d;
    logic              sh;
    logic              tl;
  } exp_t;

  logic              clk = 1'b0;
  logic              clr = 1'b1;
  logic              start = 1'b0;
  logic [BPREC-1:0]  pw = '0, pd = '0;
  logic [BWADDR-1:0] wbase = '0, dbase = '0;
  logic [BTILE-1:0]  ntile = '0;
  logic              stall = 1'b0;
  logic [BPREC-1:0]  zz_offw, zz_offd;
  logic              zz_step, zz_clr, busy, done, valid, acc_sh, tile_last;
  logic [BWADDR-1:0] waddr, daddr;

  exp_t  exp_q[$];
  int    done_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    issued = 0;
  int    start_cyc = 0;
  logic [BPREC-1:0] agu_pw = 4'd1;
  logic [BPREC-1:0] aw, ad;

  zz_sched #(.BWADDR(BWADDR), .BPREC(BPREC), .BTILE(BTILE)) dut (
    .clk(clk), .clr(clr), .start(start), .pw(pw), .pd(pd),
    .wbase(wbase), .dbase(dbase), .ntile(ntile), .stall(stall),
    .zz_offw(zz_offw), .zz_offd(zz_offd), .zz_step(zz_step), .zz_clr(zz_clr),
    .busy(busy), .done(done), .valid(valid), .waddr(waddr), .daddr(daddr),
    .acc_sh(acc_sh), .tile_last(tile_last)
  );

  always #5 clk = ~clk;

  // Zig-zag AGU: weight offset runs fastest, data offset advances on wrap.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      aw <= '0;
      ad <= '0;
    end else if (zz_clr) begin
      aw <= '0;
      ad <= '0;
    end else if (zz_step) begin
      if (aw == agu_pw - 4'd1) begin
        aw <= '0;
        ad <= ad + 4'd1;
      end else begin
        aw <= aw + 4'd1;
      end
    end
  end
  assign zz_offw = aw;
  assign zz_offd = ad;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid && !clr) issued <= issued + 1;
  end

  always @(negedge clk) begin
    if (!clr) begin
      if (valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_valid: got waddr=%0d daddr=%0d, required no product", waddr, daddr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (waddr !== e.w || daddr !== e.d || acc_sh !== e.sh || tile_last !== e.tl ||
              zz_step !== 1'b1 || zz_clr !== e.tl) begin
            n_bad++;
            $display("FAIL product: got w=%0d d=%0d sh=%b tl=%b step=%b clr=%b, required w=%0d d=%0d sh=%b tl=%b step=1 clr=%b",
                     waddr, daddr, acc_sh, tile_last, zz_step, zz_clr, e.w, e.d, e.sh, e.tl, e.tl);
          end
        end
      end
      if (done) begin
        n_vec++;
        if (done_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc - start_cyc);
        end else begin
          int lat;
          lat = done_q.pop_front();
          if (cyc - start_cyc != lat) begin
            n_bad++;
            $display("FAIL done_latency: got %0d, required %0d", cyc - start_cyc, lat);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int w, input int d, input logic sh, input logic tl);
    exp_t e;
    e.w  = BWADDR'(w);
    e.d  = BWADDR'(d);
    e.sh = sh;
    e.tl = tl;
    exp_q.push_back(e);
  endtask

  task automatic run_job(input int p_w, input int p_d, input int wb, input int db, input int nt);
    pw     = BPREC'(p_w);
    pd     = BPREC'(p_d);
    wbase  = BWADDR'(wb);
    dbase  = BWADDR'(db);
    ntile  = BTILE'(nt);
    agu_pw = BPREC'(p_w);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_issued(input int base, input int n);
    int k;
    k = 0;
    while (issued - base < n && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("wait_issued", issued - base, n);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({name, "_idle"}, busy, 1'b0);
    check({name, "_exp_drained"}, exp_q.size(), 0);
    check({name, "_done_drained"}, done_q.size(), 0);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_valid_step_clr", {valid, zz_step, zz_clr, done}, 4'b0000);
    clr = 1'b0;
    @(posedge clk);
    #1;
    check("idle_outputs", {busy, done, valid, zz_step, zz_clr, acc_sh, tile_last}, 7'b0);

    // 2x2 single tile
    push(100, 200, 0, 0); push(101, 200, 1, 0); push(100, 201, 0, 0); push(101, 201, 1, 1);
    done_q.push_back(5);
    run_job(2, 2, 100, 200, 1);
    check("init_busy", busy, 1'b1);
    check("init_zz_clr", zz_clr, 1'b1);
    wait_idle("basic");

    // 1x1, three tiles
    push(0, 8, 0, 1); push(1, 9, 0, 1); push(2, 10, 0, 1);
    done_q.push_back(4);
    run_job(1, 1, 0, 8, 3);
    wait_idle("unit");

    // stall for 3 cycles after product 2
    push(100, 200, 0, 0); push(101, 200, 1, 0); push(100, 201, 0, 0); push(101, 201, 1, 1);
    done_q.push_back(8);
    base = issued;
    run_job(2, 2, 100, 200, 1);
    wait_issued(base, 2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("stall_quiet", {valid, zz_step}, 2'b00);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    wait_idle("stall");

    // zero precision
    done_q.push_back(1);
    run_job(0, 2, 5, 5, 4);
    check("pw0_busy_init", busy, 1'b1);
    @(posedge clk);
    #1;
    check("pw0_busy_done", busy, 1'b1);
    @(posedge clk);
    #1;
    check("pw0_busy_after", busy, 1'b0);
    wait_idle("pw0");

    // clr during RUN of a 3-tile job
    push(0, 0, 0, 0); push(1, 0, 1, 1); push(2, 1, 0, 0);
    base = issued;
    run_job(2, 1, 0, 0, 3);
    wait_issued(base, 3);
    clr = 1'b1;
    #1;
    check("clr_busy", busy, 1'b0);
    check("clr_valid", valid, 1'b0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("clr_no_resume", busy, 1'b0);
    push(0, 0, 0, 0); push(1, 0, 1, 1); push(2, 1, 0, 0);
    push(3, 1, 1, 1); push(4, 2, 0, 0); push(5, 2, 1, 1);
    done_q.push_back(7);
    run_job(2, 1, 0, 0, 3);
    wait_idle("rerun");

    // start while busy is ignored
    push(0, 8, 0, 1); push(1, 9, 0, 1); push(2, 10, 0, 1);
    done_q.push_back(4);
    run_job(1, 1, 0, 8, 3);
    pw    = 4'd3;
    pd    = 4'd3;
    ntile = 8'd5;
    wbase = 21'd500;
    start = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("restart_ignored");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
